// File: rtl/mp64_nic_loopback_phy.sv
// Loopback PHY model: captures one frame from the NIC transmitter, waits an
// inter-frame gap, then replays it into the NIC receiver. Link bring-up is delayed.
module mp64_nic_loopback_phy #(
    parameter int DEPTH      = 256,
    parameter int IFG        = 4,
    parameter int LINK_DELAY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_en,
    input  logic        phy_tx_valid,
    input  logic [7:0]  phy_tx_data,
    output logic        phy_tx_ready,
    output logic        phy_rx_valid,
    output logic [7:0]  phy_rx_data,
    input  logic        phy_rx_ready,
    output logic        phy_link_up,
    output logic [15:0] frames_looped,
    output logic [15:0] frames_dropped,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int GW = $clog2(IFG + 1);
    localparam int DW = $clog2(LINK_DELAY + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_REPLAY  = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] len;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] link_cnt;
    logic [7:0]    mem [DEPTH];
    logic          tx_hs;
    logic          rx_hs;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic          buf_full;
    logic          last_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign phy_tx_ready = phy_link_up &&
                          (state == S_IDLE || state == S_CAPTURE || state == S_DROP);
    assign busy      = (state != S_IDLE);
    assign tx_hs     = phy_tx_valid && phy_tx_ready;
    assign rx_hs     = phy_rx_valid && phy_rx_ready;
    assign rd_next   = rd_ptr + AW'(1);
    assign buf_full  = (len == LW'(DEPTH));
    assign last_byte = ({1'b0, rd_ptr} == (len - LW'(1)));

    // Writes only for bytes that are actually kept in the frame
    assign buf_we    = tx_hs && ((state == S_IDLE) ||
                                 (state == S_CAPTURE && link_en && !buf_full));
    assign buf_waddr = (state == S_IDLE) ? '0 : len[AW-1:0];

    always_ff @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= phy_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst || !link_en) begin
            link_cnt    <= '0;
            phy_link_up <= 1'b0;
        end else if (!phy_link_up) begin
            if (link_cnt == DW'(LINK_DELAY - 1)) phy_link_up <= 1'b1;
            else                                 link_cnt    <= link_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            len            <= '0;
            rd_ptr         <= '0;
            gap_cnt        <= '0;
            phy_rx_valid   <= 1'b0;
            phy_rx_data    <= 8'h00;
            frames_looped  <= '0;
            frames_dropped <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_hs) begin
                        len   <= LW'(1);
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Link loss wins over overflow so the drop is counted once
                    if (!link_en) begin
                        state          <= S_IDLE;
                        len            <= '0;
                        frames_dropped <= sat_inc(frames_dropped);
                    end else if (!phy_tx_valid) begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(IFG);
                    end else if (tx_hs) begin
                        if (buf_full) begin
                            state          <= S_DROP;
                            frames_dropped <= sat_inc(frames_dropped);
                        end else begin
                            len <= len + LW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!link_en) begin
                        state          <= S_IDLE;
                        frames_dropped <= sat_inc(frames_dropped);
                    end else if (gap_cnt == GW'(1)) begin
                        state  <= S_REPLAY;
                        rd_ptr <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_REPLAY: begin
                    if (!link_en) begin
                        state          <= S_IDLE;
                        phy_rx_valid   <= 1'b0;
                        phy_rx_data    <= 8'h00;
                        frames_dropped <= sat_inc(frames_dropped);
                    end else if (!phy_rx_valid) begin
                        phy_rx_valid <= 1'b1;
                        phy_rx_data  <= mem[rd_ptr];
                    end else if (rx_hs) begin
                        if (last_byte) begin
                            state         <= S_IDLE;
                            phy_rx_valid  <= 1'b0;
                            phy_rx_data   <= 8'h00;
                            frames_looped <= sat_inc(frames_looped);
                        end else begin
                            rd_ptr      <= rd_next;
                            phy_rx_data <= mem[rd_next];
                        end
                    end
                end
                S_DROP: begin
                    if (!link_en || !phy_tx_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_nic_loopback_phy.sv
// Directed bench for the loopback PHY: link timing, replay latency, backpressure,
// overflow drop, link loss and reset. Small DEPTH so the overflow path is reachable.
module tb_mp64_nic_loopback_phy;

    localparam int DEPTH = 4;
    localparam int IFG   = 4;
    localparam int LDLY  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_en;
    logic        phy_tx_valid;
    logic [7:0]  phy_tx_data;
    logic        phy_tx_ready;
    logic        phy_rx_valid;
    logic [7:0]  phy_rx_data;
    logic        phy_rx_ready;
    logic        phy_link_up;
    logic [15:0] frames_looped;
    logic [15:0] frames_dropped;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sbuf [8];

    mp64_nic_loopback_phy #(.DEPTH(DEPTH), .IFG(IFG), .LINK_DELAY(LDLY)) dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .phy_tx_valid(phy_tx_valid), .phy_tx_data(phy_tx_data), .phy_tx_ready(phy_tx_ready),
        .phy_rx_valid(phy_rx_valid), .phy_rx_data(phy_rx_data), .phy_rx_ready(phy_rx_ready),
        .phy_link_up(phy_link_up), .frames_looped(frames_looped),
        .frames_dropped(frames_dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            chk("tx_ready_capture", 32'(phy_tx_ready), 32'd1);
            phy_tx_valid = 1'b1;
            phy_tx_data  = sbuf[i];
            tick();
        end
        phy_tx_valid = 1'b0;
        phy_tx_data  = 8'h00;
    endtask

    // Edge that samples tx_valid low, then IFG gap edges, then rx_valid rises
    task automatic wait_gap();
        tick();
        for (int i = 0; i <= IFG; i++) begin
            chk("rx_valid_gap", 32'(phy_rx_valid), 32'd0);
            chk("rx_data_gap", 32'(phy_rx_data), 32'h00);
            chk("tx_ready_gap", 32'(phy_tx_ready), 32'd0);
            tick();
        end
        chk("rx_valid_rise", 32'(phy_rx_valid), 32'd1);
    endtask

    task automatic recv_frame(input int n, input bit stall);
        logic [3:0] pat;
        int idx;
        int k;
        pat = 4'b1001;
        idx = 0;
        k   = 0;
        for (int c = 0; c < 64 && idx < n; c++) begin
            chk("rx_valid_replay", 32'(phy_rx_valid), 32'd1);
            chk("rx_data", 32'(phy_rx_data), 32'(sbuf[idx]));
            chk("tx_ready_replay", 32'(phy_tx_ready), 32'd0);
            phy_rx_ready = stall ? pat[k % 4] : 1'b1;
            k++;
            if (phy_rx_ready) idx++;
            tick();
        end
        chk("rx_count", 32'(idx), 32'(n));
        phy_rx_ready = 1'b1;
        chk("rx_valid_end", 32'(phy_rx_valid), 32'd0);
        chk("rx_data_end", 32'(phy_rx_data), 32'h00);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic link_up_wait();
        link_en = 1'b1;
        for (int i = 1; i <= LDLY; i++) begin
            tick();
            chk("link_up_delay", 32'(phy_link_up), 32'(i == LDLY));
        end
    endtask

    initial begin
        rst          = 1'b1;
        link_en      = 1'b0;
        phy_tx_valid = 1'b0;
        phy_tx_data  = 8'h00;
        phy_rx_ready = 1'b1;
        tick();
        tick();
        chk("rst_link_up", 32'(phy_link_up), 32'd0);
        chk("rst_tx_ready", 32'(phy_tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(phy_rx_valid), 32'd0);
        chk("rst_rx_data", 32'(phy_rx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_looped", 32'(frames_looped), 32'd0);
        chk("rst_dropped", 32'(frames_dropped), 32'd0);

        // Link comes up on exactly the LDLY-th edge after release
        rst = 1'b0;
        link_up_wait();
        chk("tx_ready_idle", 32'(phy_tx_ready), 32'd1);

        // Plain loop, receiver always ready
        sbuf[0] = 8'h11; sbuf[1] = 8'h22; sbuf[2] = 8'h33; sbuf[3] = 8'h44;
        send_frame(4);
        chk("busy_capture", 32'(busy), 32'd1);
        wait_gap();
        recv_frame(4, 1'b0);
        chk("looped_1", 32'(frames_looped), 32'd1);

        // Same frame with receiver backpressure
        send_frame(4);
        wait_gap();
        recv_frame(4, 1'b1);
        chk("looped_2", 32'(frames_looped), 32'd2);

        // Overflow: 6 bytes into a 4-byte buffer
        sbuf[4] = 8'h55; sbuf[5] = 8'h66;
        send_frame(6);
        chk("busy_drop", 32'(busy), 32'd1);
        chk("dropped_ovf", 32'(frames_dropped), 32'd1);
        tick();
        chk("busy_after_drop", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_rx_after_drop", 32'(phy_rx_valid), 32'd0);
        end
        sbuf[0] = 8'hAA; sbuf[1] = 8'hBB;
        send_frame(2);
        wait_gap();
        recv_frame(2, 1'b0);
        chk("looped_3", 32'(frames_looped), 32'd3);
        chk("dropped_still_1", 32'(frames_dropped), 32'd1);

        // Link loss mid-replay after two bytes
        sbuf[0] = 8'h01; sbuf[1] = 8'h02; sbuf[2] = 8'h03; sbuf[3] = 8'h04;
        send_frame(4);
        wait_gap();
        tick();
        tick();
        chk("replay_third", 32'(phy_rx_data), 32'h03);
        link_en = 1'b0;
        tick();
        chk("loss_rx_valid", 32'(phy_rx_valid), 32'd0);
        chk("loss_rx_data", 32'(phy_rx_data), 32'h00);
        chk("loss_link_up", 32'(phy_link_up), 32'd0);
        chk("loss_busy", 32'(busy), 32'd0);
        chk("loss_dropped", 32'(frames_dropped), 32'd2);
        chk("loss_looped", 32'(frames_looped), 32'd3);

        // Overflow byte and link loss on the same edge count one drop
        link_up_wait();
        send_frame(4);
        phy_tx_valid = 1'b1;
        phy_tx_data  = 8'h77;
        link_en      = 1'b0;
        tick();
        phy_tx_valid = 1'b0;
        chk("coinc_busy", 32'(busy), 32'd0);
        chk("coinc_dropped", 32'(frames_dropped), 32'd3);
        tick();
        chk("coinc_dropped_hold", 32'(frames_dropped), 32'd3);

        // Reset mid-capture discards the frame and counts nothing
        link_up_wait();
        phy_tx_valid = 1'b1;
        phy_tx_data  = 8'h99;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_link_up", 32'(phy_link_up), 32'd0);
        chk("midrst_looped", 32'(frames_looped), 32'd0);
        chk("midrst_dropped", 32'(frames_dropped), 32'd0);
        rst          = 1'b0;
        phy_tx_valid = 1'b0;
        tick();
        chk("postrst_dropped", 32'(frames_dropped), 32'd0);
        chk("postrst_rx_valid", 32'(phy_rx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mp64_nic_loopback_phy.md
MP64_NIC_LOOPBACK_PHY -- requirements
Module: mp64_nic_loopback_phy

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning frame buffer size in bytes (power of two, max accepted frame length).
REQ-002 SHALL have parameter IFG, default 4, meaning inter-frame gap in cycles between end of captured frame and start of replay (≥1).
REQ-003 SHALL have parameter LINK_DELAY, default 8, meaning cycles from link_en rising to phy_link_up asserting (≥1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port link_en, input, 1, bench/board request to bring the link up.
REQ-007 SHALL have ports phy_tx_valid (input, 1), phy_tx_data (input, 8), phy_tx_ready (output, 1), the byte stream from the NIC transmitter; frame ends when phy_tx_valid drops.
REQ-008 SHALL have ports phy_rx_valid (output, 1), phy_rx_data (output, 8), phy_rx_ready (input, 1), the byte stream into the NIC receiver; frame ends when phy_rx_valid drops.
REQ-009 SHALL have port phy_link_up, output, 1, link status to the NIC.
REQ-010 SHALL have ports frames_looped (output, 16) and frames_dropped (output, 16), saturating frame counters.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL transfer a byte on either stream only on a rising edge with valid && ready both high.
REQ-013 SHALL implement states IDLE, CAPTURE, GAP, REPLAY, DROP.
REQ-014 SHALL drive phy_tx_ready = phy_link_up in IDLE, CAPTURE and DROP; 0 in GAP and REPLAY.
REQ-015 IDLE: first accepted tx byte SHALL be written to buf[0], set len=1, go CAPTURE.
REQ-016 CAPTURE: each accepted byte SHALL be written at buf[len], len incremented; phy_tx_valid sampled low SHALL go GAP with gap counter loaded to IFG.
REQ-017 CAPTURE: a byte accepted when len==DEPTH SHALL not be stored; go DROP, frames_dropped increments that edge.
REQ-018 DROP: SHALL accept and discard bytes; phy_tx_valid sampled low SHALL go IDLE.
REQ-019 GAP: SHALL last exactly IFG cycles, then go REPLAY with rd_ptr=0.
REQ-020 REPLAY: phy_rx_valid SHALL be registered high, phy_rx_data = buf[rd_ptr]; rd_ptr advances only on rx handshake; data SHALL hold stable while phy_rx_ready is low.
REQ-021 REPLAY: handshake on byte len-1 SHALL drop phy_rx_valid on that same edge, increment frames_looped, go IDLE.
REQ-022 phy_rx_data SHALL read 8'h00 whenever phy_rx_valid is low.
REQ-023 Link FSM: counter SHALL start when link_en is high; phy_link_up asserts after LINK_DELAY consecutive link_en-high cycles.
REQ-024 link_en low SHALL clear phy_link_up and the counter on the next edge.
REQ-025 Link loss in CAPTURE, GAP or REPLAY SHALL abort to IDLE on that edge, drop phy_rx_valid, and increment frames_dropped.
REQ-026 Link loss in DROP SHALL go IDLE with no further count increment.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 If overflow and link loss coincide on one edge, SHALL increment frames_dropped exactly once.

Reset
REQ-029 rst SHALL force state IDLE, len=0, rd_ptr=0, gap/link counters 0, phy_link_up=0, phy_tx_ready=0, phy_rx_valid=0, phy_rx_data=0, busy=0, both frame counters 0.
REQ-030 rst mid-frame SHALL discard buffered data; no counter SHALL increment.
REQ-031 Buffer contents need not be reset.

Verification
REQ-032 link_en=1 from reset release -> phy_link_up high on exactly the 8th edge, not the 7th; link_en=0 -> low on next edge.
REQ-033 Send 11 22 33 44, then tx_valid low, rx_ready=1 -> rx_valid rises IFG+1 edges after tx_valid sampled low; bytes 11 22 33 44 contiguous; frames_looped=1.
REQ-034 Same frame with rx_ready toggling 1,0,0,1,... -> each byte held while ready low, no duplicates or skips; tx_ready=0 throughout GAP/REPLAY.
REQ-035 DEPTH=4: 6-byte frame -> DROP, frames_dropped=1, no rx_valid; next 2-byte frame loops normally.
REQ-036 link_en dropped during REPLAY after 2 of 4 bytes -> rx_valid low next edge, IDLE, frames_dropped+1, frames_looped unchanged.
